// File: rtl/mem_stage.sv
// mem_stage: byte-serial load/store stage between EX/MEM and MEM/WB, one byte per req/ack handshake.
// Optional per-byte acknowledge timeout is enabled by defining MEM_ACK_TIMEOUT_EN.
`ifndef AluOpBus
  `define AluOpBus 7:0
`endif
`ifndef REQ_NOP
  `define REQ_NOP 2'b00
`endif
`ifndef REQ_STALL
  `define REQ_STALL 2'b01
`endif
`ifndef EXE_LB_OP
  `define EXE_LB_OP  8'h80
  `define EXE_LH_OP  8'h81
  `define EXE_LW_OP  8'h83
  `define EXE_LBU_OP 8'h84
  `define EXE_LHU_OP 8'h85
  `define EXE_SB_OP  8'h88
  `define EXE_SH_OP  8'h89
  `define EXE_SW_OP  8'h8B
`endif

module mem_stage
`ifdef MEM_ACK_TIMEOUT_EN
  #(parameter int unsigned TIMEOUT = 255)
`endif
(
  input  logic              clk,
  input  logic              rst,
  input  logic [`AluOpBus]  aluop_EXMEM_i,
  input  logic              wreg_EXMEM_i,
  input  logic [4:0]        waddr_EXMEM_i,
  input  logic [31:0]       alurslt_EXMEM_i,
  input  logic [31:0]       SdataBoffset_EXMEM_i,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [31:0]       mem_addr_o,
  output logic [7:0]        mem_wdata_o,
  input  logic [7:0]        mem_rdata_i,
  input  logic              mem_ack_i,
  output logic              wreg_MEMWB_o,
  output logic [4:0]        waddr_MEMWB_o,
  output logic [31:0]       wdata_MEMWB_o,
  output logic [1:0]        rq_STALLER_o
);
  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned RW = 5;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] XFER = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [AW-1:0] base_q, base_d;
  logic [1:0]    last_q, last_d;  // index of the final byte: 0, 1 or 3
  logic          store_q, store_d;
  logic          sgn_q, sgn_d;
  logic          wreg_q, wreg_d;
  logic [RW-1:0] waddr_q, waddr_d;
  logic [DW-1:0] sdata_q, sdata_d;
  logic [DW-1:0] asm_q, asm_d;
  logic [1:0]    idx_q, idx_d;
`ifdef MEM_ACK_TIMEOUT_EN
  logic [7:0]    wait_q, wait_d;
  logic          tmo_q, tmo_d;
`endif

  logic          is_mem;
  logic          dec_store;
  logic          dec_sgn;
  logic [1:0]    dec_last;
  logic [DW-1:0] load_val;

  // Opcode decode: memory op, direction, signedness and size
  always_comb begin
    is_mem    = 1'b1;
    dec_store = 1'b0;
    dec_sgn   = 1'b0;
    dec_last  = 2'd0;
    case (aluop_EXMEM_i)
      `EXE_LB_OP:  dec_sgn = 1'b1;
      `EXE_LBU_OP: dec_last = 2'd0;
      `EXE_LH_OP:  begin dec_sgn = 1'b1; dec_last = 2'd1; end
      `EXE_LHU_OP: dec_last = 2'd1;
      `EXE_LW_OP:  dec_last = 2'd3;
      `EXE_SB_OP:  dec_store = 1'b1;
      `EXE_SH_OP:  begin dec_store = 1'b1; dec_last = 2'd1; end
      `EXE_SW_OP:  begin dec_store = 1'b1; dec_last = 2'd3; end
      default:     is_mem = 1'b0;
    endcase
  end

  // Extend the assembled bytes to the register width
  always_comb begin
    case (last_q)
      2'd0:    load_val = {{24{sgn_q & asm_q[7]}}, asm_q[7:0]};
      2'd1:    load_val = {{16{sgn_q & asm_q[15]}}, asm_q[15:0]};
      default: load_val = asm_q;
    endcase
`ifdef MEM_ACK_TIMEOUT_EN
    if (tmo_q) load_val = '0;
`endif
  end

  always_comb begin
    state_d = state_q;
    base_d  = base_q;
    last_d  = last_q;
    store_d = store_q;
    sgn_d   = sgn_q;
    wreg_d  = wreg_q;
    waddr_d = waddr_q;
    sdata_d = sdata_q;
    asm_d   = asm_q;
    idx_d   = idx_q;
`ifdef MEM_ACK_TIMEOUT_EN
    wait_d  = wait_q;
    tmo_d   = tmo_q;
`endif
    mem_req_o     = 1'b0;
    mem_we_o      = 1'b0;
    mem_addr_o    = '0;
    mem_wdata_o   = '0;
    wreg_MEMWB_o  = 1'b0;
    waddr_MEMWB_o = '0;
    wdata_MEMWB_o = '0;
    rq_STALLER_o  = `REQ_NOP;
    case (state_q)
      IDLE: begin
        if (is_mem) begin
          state_d      = XFER;
          base_d       = alurslt_EXMEM_i;
          last_d       = dec_last;
          store_d      = dec_store;
          sgn_d        = dec_sgn;
          wreg_d       = wreg_EXMEM_i;
          waddr_d      = waddr_EXMEM_i;
          sdata_d      = SdataBoffset_EXMEM_i;
          asm_d        = '0;
          idx_d        = '0;
`ifdef MEM_ACK_TIMEOUT_EN
          wait_d       = '0;
          tmo_d        = 1'b0;
`endif
          rq_STALLER_o = `REQ_STALL;
        end else begin
          wreg_MEMWB_o  = wreg_EXMEM_i;
          waddr_MEMWB_o = waddr_EXMEM_i;
          wdata_MEMWB_o = alurslt_EXMEM_i;
        end
      end
      XFER: begin
        mem_req_o    = 1'b1;
        mem_we_o     = store_q;
        mem_addr_o   = base_q + AW'(idx_q);
        mem_wdata_o  = sdata_q[{idx_q, 3'b000} +: 8];
        rq_STALLER_o = `REQ_STALL;
        if (mem_ack_i) begin
          if (!store_q) asm_d[{idx_q, 3'b000} +: 8] = mem_rdata_i;
          idx_d = idx_q + 2'd1;
          if (idx_q == last_q) state_d = DONE;
`ifdef MEM_ACK_TIMEOUT_EN
          wait_d = '0;
        end else if (wait_q == 8'(TIMEOUT - 1)) begin
          tmo_d   = 1'b1;
          state_d = DONE;
        end else begin
          wait_d = wait_q + 8'd1;
`endif
        end
      end
      DONE: begin
        state_d       = IDLE;
        waddr_MEMWB_o = waddr_q;
        if (!store_q) begin
          wreg_MEMWB_o  = wreg_q;
          wdata_MEMWB_o = load_val;
        end
      end
      default: state_d = IDLE;
    endcase
    // Reset forces every output, including the pass-through path, to its idle value
    if (!rst) begin
      mem_req_o     = 1'b0;
      mem_we_o      = 1'b0;
      mem_addr_o    = '0;
      mem_wdata_o   = '0;
      wreg_MEMWB_o  = 1'b0;
      waddr_MEMWB_o = '0;
      wdata_MEMWB_o = '0;
      rq_STALLER_o  = `REQ_NOP;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      base_q  <= '0;
      last_q  <= '0;
      store_q <= 1'b0;
      sgn_q   <= 1'b0;
      wreg_q  <= 1'b0;
      waddr_q <= '0;
      sdata_q <= '0;
      asm_q   <= '0;
      idx_q   <= '0;
`ifdef MEM_ACK_TIMEOUT_EN
      wait_q  <= '0;
      tmo_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      last_q  <= last_d;
      store_q <= store_d;
      sgn_q   <= sgn_d;
      wreg_q  <= wreg_d;
      waddr_q <= waddr_d;
      sdata_q <= sdata_d;
      asm_q   <= asm_d;
      idx_q   <= idx_d;
`ifdef MEM_ACK_TIMEOUT_EN
      wait_q  <= wait_d;
      tmo_q   <= tmo_d;
`endif
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Directed self-checking bench for mem_stage with a byte-wide memory responder of programmable ack delay.
`timescale 1ns/1ps
`ifndef AluOpBus
  `define AluOpBus 7:0
`endif
`ifndef REQ_NOP
  `define REQ_NOP 2'b00
`endif
`ifndef REQ_STALL
  `define REQ_STALL 2'b01
`endif
`ifndef EXE_LB_OP
  `define EXE_LB_OP  8'h80
  `define EXE_LH_OP  8'h81
  `define EXE_LW_OP  8'h83
  `define EXE_LBU_OP 8'h84
  `define EXE_LHU_OP 8'h85
  `define EXE_SB_OP  8'h88
  `define EXE_SH_OP  8'h89
  `define EXE_SW_OP  8'h8B
`endif

module tb_mem_stage;
  localparam logic [7:0] OP_NOP = 8'h00;
  localparam logic [7:0] OP_ADD = 8'h20;

  logic        clk;
  logic        rst;
  logic [7:0]  aluop_i;
  logic        wreg_i;
  logic [4:0]  waddr_i;
  logic [31:0] alurslt_i;
  logic [31:0] sdata_i;
  logic        mem_req, mem_we, mem_ack;
  logic [31:0] mem_addr;
  logic [7:0]  mem_wdata, mem_rdata;
  logic        wreg_o;
  logic [4:0]  waddr_o;
  logic [31:0] wdata_o;
  logic [1:0]  rq_o;

  int checks = 0;
  int errors = 0;

  logic [7:0]  rdmem [16];
  int          ack_delay = 0;
  logic        ack_en = 1'b1;
  int          wcnt = 0;
  int          req_cycles = 0;
  logic [31:0] acc_addr [$];
  logic [7:0]  acc_data [$];
  logic        acc_we [$];
  logic        pend = 1'b0;
  logic        unstable = 1'b0;
  logic [31:0] p_addr;
  logic [7:0]  p_wdata;
  logic        p_we;

`ifdef MEM_ACK_TIMEOUT_EN
  mem_stage #(.TIMEOUT(4)) dut (
`else
  mem_stage dut (
`endif
    .clk(clk), .rst(rst),
    .aluop_EXMEM_i(aluop_i), .wreg_EXMEM_i(wreg_i), .waddr_EXMEM_i(waddr_i),
    .alurslt_EXMEM_i(alurslt_i), .SdataBoffset_EXMEM_i(sdata_i),
    .mem_req_o(mem_req), .mem_we_o(mem_we), .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata),
    .mem_rdata_i(mem_rdata), .mem_ack_i(mem_ack),
    .wreg_MEMWB_o(wreg_o), .waddr_MEMWB_o(waddr_o), .wdata_MEMWB_o(wdata_o),
    .rq_STALLER_o(rq_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign mem_ack   = mem_req && ack_en && (wcnt >= ack_delay);
  assign mem_rdata = rdmem[mem_addr[3:0]];

  // Memory responder: wait counter, transfer log, req-stability watch
  always @(posedge clk) begin
    if (mem_req) req_cycles = req_cycles + 1;
    if (pend && mem_req && (mem_addr !== p_addr || mem_wdata !== p_wdata || mem_we !== p_we))
      unstable = 1'b1;
    if (mem_req && mem_ack) begin
      acc_addr.push_back(mem_addr);
      acc_data.push_back(mem_wdata);
      acc_we.push_back(mem_we);
    end
    pend    = mem_req && !mem_ack;
    p_addr  = mem_addr;
    p_wdata = mem_wdata;
    p_we    = mem_we;
    if (!mem_req || mem_ack) wcnt = 0;
    else wcnt = wcnt + 1;
  end

  task automatic clear_log();
    acc_addr.delete();
    acc_data.delete();
    acc_we.delete();
    unstable   = 1'b0;
    req_cycles = 0;
  endtask

  // Applies one memory op and samples each cycle until rq returns to NOP (DONE)
  task automatic run_op(input logic [7:0] op, input logic [31:0] addr, input logic [31:0] sd,
                        input logic [4:0] wa, input int delay,
                        output int cycles, output int stalls, output logic stall_wreg_bad,
                        output logic wr_r, output logic [4:0] wa_r, output logic [31:0] wd_r);
    aluop_i = op; wreg_i = 1'b1; waddr_i = wa; alurslt_i = addr; sdata_i = sd;
    ack_delay = delay;
    clear_log();
    cycles = 0; stalls = 0; stall_wreg_bad = 1'b0;
    wr_r = 1'b0; wa_r = '0; wd_r = '0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      cycles++;
      if (rq_o === `REQ_STALL) begin
        stalls++;
        if (wreg_o !== 1'b0) stall_wreg_bad = 1'b1;
      end else begin
        wr_r = wreg_o; wa_r = waddr_o; wd_r = wdata_o;
        break;
      end
    end
    @(posedge clk); #1;
    aluop_i = OP_NOP; wreg_i = 1'b0; waddr_i = '0; alurslt_i = '0; sdata_i = '0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    aluop_i = OP_ADD; wreg_i = 1'b1; waddr_i = 5'd7; alurslt_i = 32'hCAFE_0001; sdata_i = 32'h1;
    #3;
    checks++; if (wreg_o !== 1'b0) begin errors++; $display("FAIL reset_wreg: got %b expected 0", wreg_o); end
    checks++; if (waddr_o !== 5'd0) begin errors++; $display("FAIL reset_waddr: got %0d expected 0", waddr_o); end
    checks++; if (wdata_o !== 32'h0) begin errors++; $display("FAIL reset_wdata: got %h expected 0", wdata_o); end
    checks++; if (rq_o !== `REQ_NOP) begin errors++; $display("FAIL reset_rq: got %b expected %b", rq_o, `REQ_NOP); end
    checks++; if (mem_req !== 1'b0 || mem_we !== 1'b0) begin errors++; $display("FAIL reset_req_we: got %b%b expected 00", mem_req, mem_we); end
    checks++; if (mem_addr !== 32'h0 || mem_wdata !== 8'h0) begin errors++; $display("FAIL reset_addr_wdata: got %h/%h expected 0/0", mem_addr, mem_wdata); end
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_passthrough();
    aluop_i = OP_ADD; wreg_i = 1'b1; waddr_i = 5'd5; alurslt_i = 32'h0000_1234;
    @(negedge clk);
    checks++; if (wreg_o !== 1'b1 || waddr_o !== 5'd5) begin errors++; $display("FAIL pass_add_ctl: got %b/%0d expected 1/5", wreg_o, waddr_o); end
    checks++; if (wdata_o !== 32'h0000_1234) begin errors++; $display("FAIL pass_add_data: got %h expected 00001234", wdata_o); end
    checks++; if (rq_o !== `REQ_NOP || mem_req !== 1'b0) begin errors++; $display("FAIL pass_add_rq: got rq=%b req=%b expected 00/0", rq_o, mem_req); end
    // Second vector changes inputs mid-cycle: output must follow with no clock edge
    #1; wreg_i = 1'b0; waddr_i = 5'd31; alurslt_i = 32'hDEAD_BEEF;
    #1;
    checks++; if (wreg_o !== 1'b0 || waddr_o !== 5'd31 || wdata_o !== 32'hDEAD_BEEF) begin
      errors++; $display("FAIL pass_comb: got %b/%0d/%h expected 0/31/deadbeef", wreg_o, waddr_o, wdata_o); end
    @(posedge clk); #1;
    aluop_i = OP_NOP; wreg_i = 1'b0; waddr_i = '0; alurslt_i = '0;
  endtask

  task automatic test_lw();
    int cyc, st; logic bad, wr; logic [4:0] wa; logic [31:0] wd;
    rdmem[0] = 8'h78; rdmem[1] = 8'h56; rdmem[2] = 8'h34; rdmem[3] = 8'h12;
    run_op(`EXE_LW_OP, 32'h100, 32'h0, 5'd10, 0, cyc, st, bad, wr, wa, wd);
    checks++; if (cyc !== 6) begin errors++; $display("FAIL lw_latency: got %0d expected 6", cyc); end
    checks++; if (st !== 5 || bad !== 1'b0) begin errors++; $display("FAIL lw_stall: got %0d stalls bad=%b expected 5/0", st, bad); end
    checks++; if (wd !== 32'h1234_5678) begin errors++; $display("FAIL lw_data: got %h expected 12345678", wd); end
    checks++; if (wr !== 1'b1 || wa !== 5'd10) begin errors++; $display("FAIL lw_wb: got %b/%0d expected 1/10", wr, wa); end
    checks++; if (acc_addr.size() !== 4) begin errors++; $display("FAIL lw_nbytes: got %0d expected 4", acc_addr.size()); end
    else for (int i = 0; i < 4; i++) begin
      checks++; if (acc_addr[i] !== 32'h100 + 32'(i) || acc_we[i] !== 1'b0) begin
        errors++; $display("FAIL lw_addr%0d: got %h we=%b expected %h we=0", i, acc_addr[i], acc_we[i], 32'h100 + 32'(i)); end
    end
    checks++; if (req_cycles !== 4) begin errors++; $display("FAIL lw_req_cycles: got %0d expected 4", req_cycles); end
  endtask

  task automatic test_sign_ext();
    int cyc, st; logic bad, wr; logic [4:0] wa; logic [31:0] wd;
    rdmem[0] = 8'h80;
    run_op(`EXE_LB_OP, 32'h80, 32'h0, 5'd3, 0, cyc, st, bad, wr, wa, wd);
    checks++; if (wd !== 32'hFFFF_FF80 || cyc !== 3) begin errors++; $display("FAIL lb: got %h in %0d cycles expected ffffff80 in 3", wd, cyc); end
    run_op(`EXE_LBU_OP, 32'h80, 32'h0, 5'd4, 0, cyc, st, bad, wr, wa, wd);
    checks++; if (wd !== 32'h0000_0080 || cyc !== 3) begin errors++; $display("FAIL lbu: got %h in %0d cycles expected 00000080 in 3", wd, cyc); end
    rdmem[0] = 8'h01; rdmem[1] = 8'h80;
    run_op(`EXE_LH_OP, 32'h200, 32'h0, 5'd6, 0, cyc, st, bad, wr, wa, wd);
    checks++; if (wd !== 32'hFFFF_8001 || cyc !== 4) begin errors++; $display("FAIL lh: got %h in %0d cycles expected ffff8001 in 4", wd, cyc); end
    run_op(`EXE_LHU_OP, 32'h200, 32'h0, 5'd6, 0, cyc, st, bad, wr, wa, wd);
    checks++; if (wd !== 32'h0000_8001) begin errors++; $display("FAIL lhu: got %h expected 00008001", wd); end
  endtask

  task automatic test_store_wrap();
    int cyc, st; logic bad, wr; logic [4:0] wa; logic [31:0] wd;
    run_op(`EXE_SH_OP, 32'hFFFF_FFFF, 32'hAABB_CCDD, 5'd9, 2, cyc, st, bad, wr, wa, wd);
    checks++; if (cyc !== 8) begin errors++; $display("FAIL sh_latency: got %0d expected 8", cyc); end
    checks++; if (wr !== 1'b0 || wd !== 32'h0) begin errors++; $display("FAIL sh_wb: got %b/%h expected 0/00000000", wr, wd); end
    checks++; if (unstable !== 1'b0) begin errors++; $display("FAIL sh_stable: got changed=%b expected 0", unstable); end
    checks++; if (acc_addr.size() !== 2) begin errors++; $display("FAIL sh_nbytes: got %0d expected 2", acc_addr.size()); end
    else begin
      checks++; if (acc_addr[0] !== 32'hFFFF_FFFF || acc_data[0] !== 8'hDD || acc_we[0] !== 1'b1) begin
        errors++; $display("FAIL sh_byte0: got %h@%h we=%b expected dd@ffffffff we=1", acc_data[0], acc_addr[0], acc_we[0]); end
      checks++; if (acc_addr[1] !== 32'h0 || acc_data[1] !== 8'hCC || acc_we[1] !== 1'b1) begin
        errors++; $display("FAIL sh_byte1: got %h@%h we=%b expected cc@00000000 we=1", acc_data[1], acc_addr[1], acc_we[1]); end
    end
  endtask

  task automatic test_back_to_back();
    int cyc, st; logic bad, wr; logic [4:0] wa; logic [31:0] wd;
    run_op(`EXE_SB_OP, 32'h40, 32'h0000_005A, 5'd1, 0, cyc, st, bad, wr, wa, wd);
    checks++; if (cyc !== 3 || acc_data.size() !== 1) begin errors++; $display("FAIL b2b_sb: got %0d cycles %0d bytes expected 3/1", cyc, acc_data.size()); end
    else begin
      checks++; if (acc_data[0] !== 8'h5A || acc_addr[0] !== 32'h40) begin errors++; $display("FAIL b2b_sb_byte: got %h@%h expected 5a@00000040", acc_data[0], acc_addr[0]); end
    end
    rdmem[1] = 8'h7E;
    run_op(`EXE_LB_OP, 32'h41, 32'h0, 5'd2, 0, cyc, st, bad, wr, wa, wd);
    checks++; if (cyc !== 3 || wd !== 32'h0000_007E || wa !== 5'd2) begin
      errors++; $display("FAIL b2b_lb: got %0d cycles %h r%0d expected 3 0000007e r2", cyc, wd, wa); end
  endtask

  task automatic test_reset_mid_xfer();
    int cyc, st; logic bad, wr; logic [4:0] wa; logic [31:0] wd; logic found;
    aluop_i = `EXE_SW_OP; wreg_i = 1'b1; waddr_i = 5'd8; alurslt_i = 32'h300; sdata_i = 32'h1122_3344;
    ack_delay = 1;
    clear_log();
    found = 1'b0;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      if (mem_req === 1'b1 && mem_addr === 32'h301) begin found = 1'b1; break; end
    end
    checks++; if (found !== 1'b1) begin errors++; $display("FAIL rst_mid_reach: got %b expected 1", found); end
    #1 rst = 1'b0;
    #1;
    checks++; if (mem_req !== 1'b0 || mem_we !== 1'b0 || mem_addr !== 32'h0 || mem_wdata !== 8'h0) begin
      errors++; $display("FAIL rst_mid_bus: got %b%b %h %h expected 00 00000000 00", mem_req, mem_we, mem_addr, mem_wdata); end
    checks++; if (rq_o !== `REQ_NOP || wreg_o !== 1'b0 || waddr_o !== 5'd0 || wdata_o !== 32'h0) begin
      errors++; $display("FAIL rst_mid_wb: got %b %b %0d %h expected 00 0 0 0", rq_o, wreg_o, waddr_o, wdata_o); end
    repeat (2) @(posedge clk);
    @(negedge clk);
    aluop_i = OP_NOP; wreg_i = 1'b0; waddr_i = '0; alurslt_i = '0; sdata_i = '0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (acc_addr.size() !== 1 || mem_req !== 1'b0) begin
      errors++; $display("FAIL rst_mid_bytes: got %0d bytes req=%b expected 1/0", acc_addr.size(), mem_req); end
    @(posedge clk); #1;
    rdmem[0] = 8'hF0;
    run_op(`EXE_LBU_OP, 32'h80, 32'h0, 5'd12, 0, cyc, st, bad, wr, wa, wd);
    checks++; if (cyc !== 3 || wd !== 32'h0000_00F0 || wr !== 1'b1 || wa !== 5'd12) begin
      errors++; $display("FAIL rst_mid_next: got %0d cycles %h %b r%0d expected 3 000000f0 1 r12", cyc, wd, wr, wa); end
  endtask

`ifdef MEM_ACK_TIMEOUT_EN
  task automatic test_timeout();
    int cyc, st; logic bad, wr; logic [4:0] wa; logic [31:0] wd;
    ack_en = 1'b0;
    rdmem[0] = 8'h11;
    run_op(`EXE_LW_OP, 32'h100, 32'h0, 5'd9, 0, cyc, st, bad, wr, wa, wd);
    ack_en = 1'b1;
    checks++; if (req_cycles !== 4) begin errors++; $display("FAIL tmo_req_cycles: got %0d expected 4", req_cycles); end
    checks++; if (cyc !== 6) begin errors++; $display("FAIL tmo_latency: got %0d expected 6", cyc); end
    checks++; if (wd !== 32'h0 || wr !== 1'b1 || wa !== 5'd9) begin
      errors++; $display("FAIL tmo_wb: got %h %b r%0d expected 00000000 1 r9", wd, wr, wa); end
  endtask
`endif

  initial begin
    for (int i = 0; i < 16; i++) rdmem[i] = 8'h00;
    aluop_i = OP_NOP; wreg_i = 1'b0; waddr_i = '0; alurslt_i = '0; sdata_i = '0;
    rst = 1'b0;
    test_reset();
    test_passthrough();
    test_lw();
    test_sign_ext();
    test_store_wrap();
    test_back_to_back();
    test_reset_mid_xfer();
`ifdef MEM_ACK_TIMEOUT_EN
    test_timeout();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
